// File: rtl/contador_pulsos_pkg.sv
// Shared types and default sizing for the pulse counter front end.
// The default count width matches the BCD translator's count input.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int CNT_WIDTH   = 5;
  localparam int CNT_MAX     = 31;
  localparam int DEB_DEFAULT = 4;

endpackage

// File: rtl/contador_pulsos_debouncer.sv
// Two-flop synchronizer followed by a level debouncer. It emits a one-cycle
// `accepted` strobe on the edge where a high level becomes qualified.
//
// state     | meaning
// IDLE_LOW  | input settled low, waiting for a high sample
// WAIT_HIGH | input high, counting consecutive high samples
// HIGH      | input settled high, pulse already accepted
// WAIT_LOW  | input low, counting consecutive low samples
module pulse_debouncer
  import contador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic accepted
);

  localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  deb_state_t state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= IDLE_LOW;
      timer <= '0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      unique case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            timer <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2)               state <= IDLE_LOW;
          else if (timer == T_LAST) state <= HIGH;
          else                      timer <= timer + TW'(1);
        end
        HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            timer <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2)                state <= HIGH;
          else if (timer == T_LAST) state <= IDLE_LOW;
          else                      timer <= timer + TW'(1);
        end
        default: state <= IDLE_LOW;
      endcase
    end
  end

  // Combinational so the count moves on the same edge the FSM enters HIGH.
  assign accepted = (state == WAIT_HIGH) && sync2 && (timer == T_LAST);

endmodule

// File: rtl/contador_pulsos.sv
// Debounced pulse counter feeding the BCD translator: counts qualified
// rising levels of pulse_in, with wrap or saturate at MAX_COUNT.
module contador_pulsos
  import contador_pkg::*;
#(
  parameter int WIDTH           = CNT_WIDTH,
  parameter int MAX_COUNT       = CNT_MAX,
  parameter int DEBOUNCE_CYCLES = DEB_DEFAULT,
  parameter bit WRAP            = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] cuenta,
  output logic             count_stb,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic accepted;

  pulse_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .accepted (accepted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta    <= '0;
      count_stb <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      count_stb <= 1'b0;
      // In wrap mode overflow is a strobe; in saturate mode it is sticky.
      if (WRAP) overflow <= 1'b0;
      if (clear) begin
        cuenta   <= '0;
        overflow <= 1'b0;
      end else if (accepted && enable) begin
        if (cuenta < MAX_V) begin
          cuenta    <= cuenta + WIDTH'(1);
          count_stb <= 1'b1;
        end else if (WRAP) begin
          cuenta    <= '0;
          count_stb <= 1'b1;
          overflow  <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_contador_pulsos.sv
// Directed bench for contador_pulsos: one wrapping and one saturating instance
// share the same stimulus; expected values are hand-derived edge by edge.
module tb_contador_pulsos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic [4:0] cuenta_w, cuenta_s;
  logic       stb_w, stb_s, ovf_w, ovf_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  contador_pulsos #(.WIDTH(5), .MAX_COUNT(31), .DEBOUNCE_CYCLES(4), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .enable(enable), .clear(clear),
    .cuenta(cuenta_w), .count_stb(stb_w), .overflow(ovf_w)
  );

  contador_pulsos #(.WIDTH(5), .MAX_COUNT(31), .DEBOUNCE_CYCLES(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .enable(enable), .clear(clear),
    .cuenta(cuenta_s), .count_stb(stb_s), .overflow(ovf_s)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clean_pulse();
    pulse_in = 1'b1;
    repeat (10) tick();
    pulse_in = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_val("idle_cuenta", cuenta_w, 0);
      chk_val("idle_stb", stb_w, 0);
      chk_val("idle_ovf", ovf_w, 0);
    end

    // Clean pulse: count moves exactly at edge 7, strobe only there
    pulse_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) begin
        chk_val("clean_e6_cuenta", cuenta_w, 0);
        chk_val("clean_e6_stb", stb_w, 0);
      end
      if (e == 7) begin
        chk_val("clean_e7_cuenta", cuenta_w, 1);
        chk_val("clean_e7_stb", stb_w, 1);
      end
      if (e == 8) chk_val("clean_e8_stb", stb_w, 0);
    end
    pulse_in = 1'b0;
    repeat (10) tick();
    chk_val("clean_hold_cuenta", cuenta_w, 1);

    // Glitch and bounce rejection
    do_reset();
    pulse_in = 1'b1; repeat (3) tick();
    pulse_in = 1'b0; repeat (10) tick();
    for (int r = 0; r < 3; r++) begin
      pulse_in = 1'b1; repeat (4) tick();
      pulse_in = 1'b0; repeat (2) tick();
    end
    repeat (10) tick();
    chk_val("glitch_cuenta", cuenta_w, 0);
    clean_pulse();
    chk_val("after_glitch_cuenta", cuenta_w, 1);

    // Wrap vs saturate
    do_reset();
    repeat (31) clean_pulse();
    chk_val("pre_wrap_cuenta", cuenta_w, 31);
    chk_val("pre_sat_cuenta", cuenta_s, 31);
    chk_val("pre_sat_ovf", ovf_s, 0);
    pulse_in = 1'b1;
    repeat (7) tick();
    chk_val("wrap_cuenta", cuenta_w, 0);
    chk_val("wrap_ovf", ovf_w, 1);
    chk_val("wrap_stb", stb_w, 1);
    chk_val("sat_cuenta", cuenta_s, 31);
    chk_val("sat_ovf", ovf_s, 1);
    chk_val("sat_stb", stb_s, 0);
    tick();
    chk_val("wrap_ovf_next", ovf_w, 0);
    chk_val("wrap_stb_next", stb_w, 0);
    chk_val("sat_ovf_next", ovf_s, 1);
    repeat (2) tick();
    pulse_in = 1'b0;
    repeat (10) tick();
    chk_val("wrap_cuenta_after", cuenta_w, 0);
    chk_val("sat_ovf_sticky", ovf_s, 1);
    chk_val("sat_cuenta_hold", cuenta_s, 31);
    clear = 1'b1; tick(); clear = 1'b0;
    chk_val("sat_ovf_cleared", ovf_s, 0);
    chk_val("sat_cuenta_cleared", cuenta_s, 0);

    // Clear on the acceptance edge wins over the increment
    clean_pulse();
    clean_pulse();
    chk_val("pre_clear_cuenta", cuenta_w, 2);
    pulse_in = 1'b1;
    repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_val("clear_acc_cuenta", cuenta_w, 0);
    chk_val("clear_acc_stb", stb_w, 0);
    repeat (3) tick();
    pulse_in = 1'b0;
    repeat (10) tick();
    chk_val("clear_no_recount", cuenta_w, 0);

    // enable=0: FSM runs, count frozen
    enable = 1'b0;
    pulse_in = 1'b1;
    repeat (7) tick();
    chk_val("dis_e7_cuenta", cuenta_w, 0);
    chk_val("dis_e7_stb", stb_w, 0);
    repeat (3) tick();
    pulse_in = 1'b0;
    repeat (10) tick();
    enable = 1'b1;
    chk_val("dis_cuenta", cuenta_w, 0);
    clean_pulse();
    chk_val("reenable_cuenta", cuenta_w, 1);

    // Reset mid-debounce with input held high
    repeat (4) clean_pulse();
    chk_val("pre_rst_cuenta", cuenta_w, 5);
    pulse_in = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_val("rst_mid_cuenta", cuenta_w, 0);
    repeat (6) tick();
    chk_val("rst_e6_cuenta", cuenta_w, 0);
    tick();
    chk_val("rst_e7_cuenta", cuenta_w, 1);
    chk_val("rst_e7_stb", stb_w, 1);
    repeat (10) tick();
    chk_val("held_no_recount", cuenta_w, 1);
    pulse_in = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
